i2c_target_responder: RTL and testbench
=======================================

Name: i2c_target_responder

Overview:
- Clock-oversampled I2C target (slave) that answers both write and read transactions on one bus segment.
- Sits on the translator's downstream Slave1/Slave2 buses. The existing receive-only slaves only take data in; this block is the transmitting end, returning data to the initiator on read transactions.
- The block does not use inout ports. It takes raw SCL/SDA inputs and produces an open-drain pull-low enable. The parent wraps this as `sda = sda_drive_low ? 1'b0 : 1'bz`.

Parameters:
- TARGET_ADDR, 7'h50, 7-bit address this target ACKs.
- SYNC_STAGES, 2, number of input synchronizer flops on scl_in and sda_in (minimum 2).

Ports:
- clk  input  1  system clock; must run at least 16x the SCL frequency.
- reset  input  1  synchronous, active-high reset.
- scl_in  input  1  raw SCL from the bus (asynchronous).
- sda_in  input  1  raw SDA from the bus (asynchronous).
- sda_drive_low  output  1  1 pulls SDA low; 0 releases SDA.
- tx_data  input  8  byte to return on a read; sampled when tx_load=1.
- tx_load  output  1  one-cycle pulse; tx_data is captured into the shift register on this cycle.
- rx_data  output  8  last byte received in a write transaction.
- rx_valid  output  1  one-cycle pulse when rx_data updates.
- rw_dir  output  1  R/W bit of the current addressed transaction (1 = read).
- busy  output  1  high from address match until STOP or START.
- txn_done  output  1  one-cycle pulse on STOP that ends an addressed transaction.

Behaviour:
- Reset: every output is 0, state is IDLE, shift registers and bit counter are 0. Reset mid-transaction releases SDA on the next clk edge.
- Input conditioning:
  - scl_in and sda_in each pass through SYNC_STAGES flops, then one history flop for edge detection.
  - Latency from a pin edge to the internal event is SYNC_STAGES+1 clk.
- Bus events (evaluated every clk, using synchronized signals):
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
  - SCL_RISE and SCL_FALL are the synchronized SCL edges.
- Sampling and driving:
  - Data is sampled on SCL_RISE, MSB first.
  - sda_drive_low changes only on the clk cycle of SCL_FALL, or on START/STOP/reset.
- START in any state (including a repeated START): go to ADDR, clear the bit counter, release SDA, drop busy. No txn_done is generated.
- STOP in any state: go to IDLE and release SDA. If busy was 1, pulse txn_done and clear busy.
- State machine:
  - IDLE: wait for START.
  - ADDR: shift in 8 bits on SCL_RISE.
    - After the 8th bit, if bits[7:1] == TARGET_ADDR, latch rw_dir = bit0 and set busy.
    - On the next SCL_FALL, assert sda_drive_low and go to ADDR_ACK.
    - On mismatch, go to WAIT_STOP with SDA released.
  - ADDR_ACK: on SCL_FALL, release SDA. Then:
    - If rw_dir=0: go to RX_DATA.
    - If rw_dir=1: pulse tx_load and capture tx_data in the same cycle, drive sda_drive_low = ~tx_data[7], and go to TX_DATA.
  - RX_DATA: shift 8 bits on SCL_RISE. After the 8th bit, copy the shift register to rx_data and pulse rx_valid (same cycle). On the next SCL_FALL, assert sda_drive_low and go to RX_ACK.
  - RX_ACK: on SCL_FALL, release SDA and go to RX_DATA. Every data byte is ACKed.
  - TX_DATA: on each SCL_FALL, present the next bit (sda_drive_low = ~bit). After the 8th bit's SCL_FALL, release SDA and go to TX_MACK.
  - TX_MACK: sample SDA on SCL_RISE.
    - Low (ACK): on the next SCL_FALL, pulse tx_load, capture tx_data, drive bit7, and go to TX_DATA.
    - High (NACK): go to WAIT_STOP with SDA released.
  - WAIT_STOP: SDA released; wait for START or STOP.
- Simultaneous events: STOP/START take priority over SCL edges in the same cycle.
- The bit counter is 3 bits and wraps 7->0 at each byte boundary.
- The block never stretches SCL.

Test Plan:
- Write 0x50+W, data 0xA5, STOP -> ACK low during address 9th clock and data 9th clock; rx_data=0xA5 with one rx_valid pulse; rw_dir=0; txn_done pulses once after STOP; busy=0 afterwards.
- Address 0x51+W -> sda_drive_low stays 0 for the whole transaction; no rx_valid; no txn_done; busy stays 0.
- Read 0x50+R with tx_data=0x3C, master ACK, tx_data=0xC3, master NACK, STOP -> bus bits 00111100 then 11000011; tx_load pulses exactly twice; SDA released after NACK; txn_done=1 once.
- Write 0x50+W, byte 0x12, repeated START, 0x50+R, tx_data=0x7E, NACK, STOP -> rx_data=0x12; rw_dir switches to 1; bus reads 0x7E; a single txn_done after the final STOP.
- Assert reset during the 4th bit of a read byte -> sda_drive_low=0 on the next clk and all outputs are 0. A subsequent clean write of 0x50+W, 0x99 is received correctly (rx_data=0x99).
- STOP issued in the middle of a data byte -> state returns to IDLE, txn_done pulses, no rx_valid is generated for the partial byte.

Source files
------------

// File: rtl/i2c_target_responder.sv
// ---------------------------------------------------------------------------
// i2c_target_responder
//
// I2C target that answers both write and read transactions on a single bus
// segment. The block is clocked by clk, which runs much faster than SCL, and
// it never stretches SCL. SDA is open-drain. This block only produces a
// pull-low enable, and the parent builds the tri-state pad from it.
//
// Ports
//   clk            system clock, at least 16x the SCL frequency
//   reset          synchronous, active-high reset
//   scl_in         raw SCL from the bus (asynchronous)
//   sda_in         raw SDA from the bus (asynchronous)
//   sda_drive_low  1 pulls SDA low, 0 releases it
//   tx_data        byte returned on a read, captured when tx_load pulses
//   tx_load        one-cycle pulse marking the clk edge that captured tx_data
//   rx_data        last byte received in a write transaction
//   rx_valid       one-cycle pulse when rx_data updates
//   rw_dir         R/W bit of the current addressed transaction (1 = read)
//   busy           high from address match until STOP or START
//   txn_done       one-cycle pulse on the STOP that ends an addressed transaction
// ---------------------------------------------------------------------------
module i2c_target_responder #(
  parameter logic [6:0] TARGET_ADDR = 7'h50,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_drive_low,
  input  logic [7:0] tx_data,
  output logic       tx_load,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rw_dir,
  output logic       busy,
  output logic       txn_done
);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    RX_DATA,
    RX_ACK,
    TX_DATA,
    TX_MACK,
    WAIT_STOP
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_h;
  logic                   sda_h;
  logic                   scl_s;
  logic                   sda_s;
  logic                   start_evt;
  logic                   stop_evt;
  logic                   scl_rise;
  logic                   scl_fall;
  logic [2:0]             bit_cnt;
  // Only 7 bits are stored: the 8th bit of a byte is taken straight from
  // sda_s on the edge that completes it.
  logic [6:0]             rx_shift;
  // Holds the bits still to be sent. Bit 7 goes onto the bus on the
  // capture edge itself.
  logic [6:0]             tx_shift;
  // Set once a byte is complete. On the next SCL_FALL the block acts on it:
  // it drives the ACK, or after a master ACK it loads the next tx byte.
  logic                   ack_pend;

  // Synchronizers and history flops reset to the idle-bus level (both lines
  // high). This keeps reset release from looking like an SCL edge or a bus
  // condition.
  always_ff @(posedge clk) begin
    if (reset) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_h    <= 1'b1;
      sda_h    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
      scl_h    <= scl_sync[SYNC_STAGES-1];
      sda_h    <= sda_sync[SYNC_STAGES-1];
    end
  end

  assign scl_s = scl_sync[SYNC_STAGES-1];
  assign sda_s = sda_sync[SYNC_STAGES-1];

  // A START or STOP needs SCL high on both samples, so an SDA change that
  // lands in the same clk as an SCL edge is never taken as a bus condition.
  assign start_evt = scl_s & scl_h & sda_h & ~sda_s;
  assign stop_evt  = scl_s & scl_h & ~sda_h & sda_s;
  assign scl_rise  = scl_s & ~scl_h;
  assign scl_fall  = ~scl_s & scl_h;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      bit_cnt       <= 3'd0;
      rx_shift      <= 7'd0;
      tx_shift      <= 7'd0;
      ack_pend      <= 1'b0;
      sda_drive_low <= 1'b0;
      tx_load       <= 1'b0;
      rx_data       <= 8'd0;
      rx_valid      <= 1'b0;
      rw_dir        <= 1'b0;
      busy          <= 1'b0;
      txn_done      <= 1'b0;
    end else begin
      tx_load  <= 1'b0;
      rx_valid <= 1'b0;
      txn_done <= 1'b0;

      if (start_evt) begin
        // A repeated START ends the current transaction without txn_done.
        state         <= ADDR;
        bit_cnt       <= 3'd0;
        ack_pend      <= 1'b0;
        sda_drive_low <= 1'b0;
        busy          <= 1'b0;
      end else if (stop_evt) begin
        state         <= IDLE;
        bit_cnt       <= 3'd0;
        ack_pend      <= 1'b0;
        sda_drive_low <= 1'b0;
        if (busy) begin
          txn_done <= 1'b1;
          busy     <= 1'b0;
        end
      end else begin
        case (state)
          IDLE: begin
            sda_drive_low <= 1'b0;
          end

          ADDR: begin
            if (scl_rise && !ack_pend) begin
              rx_shift <= {rx_shift[5:0], sda_s};
              bit_cnt  <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                // rx_shift now holds the 7 address bits, and sda_s is the R/W bit.
                if (rx_shift == TARGET_ADDR) begin
                  rw_dir   <= sda_s;
                  busy     <= 1'b1;
                  ack_pend <= 1'b1;
                end else begin
                  state <= WAIT_STOP;
                end
              end
            end else if (scl_fall && ack_pend) begin
              ack_pend      <= 1'b0;
              sda_drive_low <= 1'b1;
              state         <= ADDR_ACK;
            end
          end

          ADDR_ACK: begin
            if (scl_fall) begin
              bit_cnt <= 3'd0;
              if (rw_dir) begin
                tx_load       <= 1'b1;
                tx_shift      <= tx_data[6:0];
                sda_drive_low <= ~tx_data[7];
                state         <= TX_DATA;
              end else begin
                sda_drive_low <= 1'b0;
                state         <= RX_DATA;
              end
            end
          end

          RX_DATA: begin
            if (scl_rise && !ack_pend) begin
              rx_shift <= {rx_shift[5:0], sda_s};
              bit_cnt  <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                rx_data  <= {rx_shift, sda_s};
                rx_valid <= 1'b1;
                ack_pend <= 1'b1;
              end
            end else if (scl_fall && ack_pend) begin
              ack_pend      <= 1'b0;
              sda_drive_low <= 1'b1;
              state         <= RX_ACK;
            end
          end

          RX_ACK: begin
            if (scl_fall) begin
              sda_drive_low <= 1'b0;
              state         <= RX_DATA;
            end
          end

          TX_DATA: begin
            // bit_cnt counts bits already placed on the bus after bit 7.
            if (scl_fall) begin
              if (bit_cnt == 3'd7) begin
                sda_drive_low <= 1'b0;
                bit_cnt       <= 3'd0;
                state         <= TX_MACK;
              end else begin
                sda_drive_low <= ~tx_shift[6];
                tx_shift      <= {tx_shift[5:0], 1'b0};
                bit_cnt       <= bit_cnt + 3'd1;
              end
            end
          end

          TX_MACK: begin
            if (scl_rise && !ack_pend) begin
              if (!sda_s) begin
                ack_pend <= 1'b1;
              end else begin
                state <= WAIT_STOP;
              end
            end else if (scl_fall && ack_pend) begin
              ack_pend      <= 1'b0;
              bit_cnt       <= 3'd0;
              tx_load       <= 1'b1;
              tx_shift      <= tx_data[6:0];
              sda_drive_low <= ~tx_data[7];
              state         <= TX_DATA;
            end
          end

          WAIT_STOP: begin
            sda_drive_low <= 1'b0;
          end

          default: begin
            state         <= IDLE;
            sda_drive_low <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target_responder.sv
// ---------------------------------------------------------------------------
// tb_i2c_target_responder
//
// Bus-level bench for i2c_target_responder. An I2C master model drives SCL
// and SDA. The SDA wire is the wired-AND of the master and the DUT's
// pull-low enable. For every transaction the bench works out the target's
// expected behaviour from the address, the direction and the byte list:
// ACK or NACK on each byte, the bytes read back, which bytes should appear
// on rx_data, how many tx_load pulses occur, and whether the transaction
// should end with txn_done. The expected DUT strobes go into queues, and a
// monitor pops and compares them whenever the DUT raises a strobe.
// ---------------------------------------------------------------------------
module tb_i2c_target_responder;

  localparam logic [6:0] TADDR = 7'h50;
  localparam int         Q     = 80;  // quarter SCL period: 8 clk cycles

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       scl = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_bus;
  logic       sda_drive_low;
  logic [7:0] tx_data = 8'h00;
  logic       tx_load;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rw_dir;
  logic       busy;
  logic       txn_done;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] exp_rx[$];
  int         exp_load[$];
  int         exp_txn[$];

  logic sdl_seen = 1'b0;
  logic busy_seen = 1'b0;

  assign sda_bus = sda_m & ~sda_drive_low;

  always #5 clk = ~clk;

  i2c_target_responder #(
    .TARGET_ADDR (TADDR),
    .SYNC_STAGES (2)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .scl_in        (scl),
    .sda_in        (sda_bus),
    .sda_drive_low (sda_drive_low),
    .tx_data       (tx_data),
    .tx_load       (tx_load),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rw_dir        (rw_dir),
    .busy          (busy),
    .txn_done      (txn_done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: whenever the DUT raises a strobe, compare it against the
  // expectations queued by the stimulus side.
  always @(negedge clk) begin
    if (!reset) begin
      if (rx_valid) begin
        chk("rx_valid_expected", exp_rx.size() > 0, 1);
        if (exp_rx.size() > 0) chk("rx_data", rx_data, exp_rx.pop_front());
      end
      if (tx_load) begin
        chk("tx_load_expected", exp_load.size() > 0, 1);
        if (exp_load.size() > 0) void'(exp_load.pop_front());
        chk("rw_dir_at_tx_load", rw_dir, 1);
      end
      if (txn_done) begin
        chk("txn_done_expected", exp_txn.size() > 0, 1);
        if (exp_txn.size() > 0) void'(exp_txn.pop_front());
        chk("busy_clear_at_txn_done", busy, 0);
      end
    end
  end

  always @(posedge clk) begin
    if (sda_drive_low) sdl_seen = 1'b1;
    if (busy) busy_seen = 1'b1;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1);
  end

  // ---------------- master bus primitives ----------------
  task automatic i2c_start();
    sda_m = 1'b1; #Q;
    scl = 1'b1;   #Q;
    sda_m = 1'b0; #Q;
    scl = 1'b0;   #Q;
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; #Q;
    scl = 1'b1;   #Q;
    sda_m = 1'b1; #Q;
  endtask

  task automatic clock_bit(input logic b, output logic r);
    sda_m = b;  #Q;
    scl = 1'b1; #Q;
    r = sda_bus; #Q;
    scl = 1'b0; #Q;
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ackbit);
    logic r;
    for (int i = 7; i >= 0; i--) clock_bit(b[i], r);
    clock_bit(1'b1, ackbit);
  endtask

  task automatic read_byte(input logic mack, input logic [7:0] next_tx, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, r);
      d[i] = r;
    end
    tx_data = next_tx;
    clock_bit(mack ? 1'b0 : 1'b1, r);
  endtask

  // One transaction plus its expected outcome. Bytes are taken MSB-first
  // from data. The target answers only its own address. A write is ACKed
  // byte by byte and reported on rx_data. A read returns exactly the bytes
  // offered on tx_data, one tx_load per byte. A non-addressed target leaves
  // SDA high. txn_done happens only when an addressed transaction ends in
  // STOP.
  task automatic do_txn(input logic [6:0] addr, input logic rd, input int n,
                        input logic [31:0] data, input logic send_stop);
    logic       match;
    logic       a;
    logic [7:0] d;
    logic [7:0] b;
    logic [7:0] nxt;
    match = (addr == TADDR);
    tx_data = data[31:24];
    if (rd && match) for (int i = 0; i < n; i++) exp_load.push_back(i);
    i2c_start();
    write_byte({addr, rd}, a);
    chk("addr_ack", a, match ? 0 : 1);
    if (match) begin
      chk("busy_after_addr", busy, 1);
      chk("rw_dir_after_addr", rw_dir, rd);
    end
    for (int i = 0; i < n; i++) begin
      b = data[31-8*i -: 8];
      if (!rd) begin
        if (match) exp_rx.push_back(b);
        write_byte(b, a);
        chk("data_ack", a, match ? 0 : 1);
      end else begin
        nxt = (i < n - 1) ? data[23-8*i -: 8] : 8'($urandom);
        read_byte(i < n - 1, nxt, d);
        chk("read_byte", d, match ? b : 8'hFF);
      end
    end
    if (rd) chk("sda_released_after_nack", sda_drive_low, 0);
    if (send_stop) begin
      if (match) exp_txn.push_back(1);
      i2c_stop();
      repeat (4) @(negedge clk);
      chk("busy_after_stop", busy, 0);
    end
  endtask

  task automatic drained(input string tag);
    repeat (4) @(negedge clk);
    chk({tag, "_rx_left"}, exp_rx.size(), 0);
    chk({tag, "_load_left"}, exp_load.size(), 0);
    chk({tag, "_done_left"}, exp_txn.size(), 0);
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_sda_drive_low"}, sda_drive_low, 0);
    chk({tag, "_tx_load"}, tx_load, 0);
    chk({tag, "_rx_data"}, rx_data, 0);
    chk({tag, "_rx_valid"}, rx_valid, 0);
    chk({tag, "_rw_dir"}, rw_dir, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_txn_done"}, txn_done, 0);
  endtask

  initial begin
    logic       r;
    logic       a;
    logic [6:0] addr;
    logic       rd;
    int         n;
    logic       stp;

    reset = 1'b1;
    repeat (5) @(negedge clk);
    all_zero("reset");
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // Write 0x50+W, 0xA5, STOP.
    do_txn(TADDR, 1'b0, 1, 32'hA500_0000, 1'b1);
    drained("write_a5");
    chk("rx_data_hold", rx_data, 8'hA5);

    // Wrong address: the target must stay completely silent.
    sdl_seen = 1'b0;
    busy_seen = 1'b0;
    do_txn(7'h51, 1'b0, 1, 32'h5A00_0000, 1'b1);
    chk("mismatch_no_drive", sdl_seen, 0);
    chk("mismatch_no_busy", busy_seen, 0);
    drained("mismatch");

    // Read two bytes: master ACKs 0x3C and NACKs 0xC3.
    do_txn(TADDR, 1'b1, 2, 32'h3CC3_0000, 1'b1);
    drained("read_2");

    // Write 0x12, then a repeated START into a read of 0x7E.
    do_txn(TADDR, 1'b0, 1, 32'h1200_0000, 1'b0);
    do_txn(TADDR, 1'b1, 1, 32'h7E00_0000, 1'b1);
    drained("rep_start");
    chk("rx_after_rep_start", rx_data, 8'h12);

    // Reset during the 4th bit of a read byte (all bits 0, so SDA is driven).
    exp_load.push_back(0);
    tx_data = 8'h00;
    i2c_start();
    write_byte({TADDR, 1'b1}, a);
    chk("rst_addr_ack", a, 0);
    for (int i = 0; i < 3; i++) clock_bit(1'b1, r);
    sda_m = 1'b1; #Q;
    scl = 1'b1;   #Q;
    chk("drive_before_reset", sda_drive_low, 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    all_zero("mid_reset");
    repeat (3) @(negedge clk);
    reset = 1'b0;
    scl = 1'b0; #Q;
    i2c_stop();
    drained("after_reset");
    do_txn(TADDR, 1'b0, 1, 32'h9900_0000, 1'b1);
    drained("post_reset_write");
    chk("rx_post_reset", rx_data, 8'h99);

    // STOP in the middle of a data byte: txn_done but no rx_valid.
    exp_txn.push_back(1);
    i2c_start();
    write_byte({TADDR, 1'b0}, a);
    chk("partial_addr_ack", a, 0);
    for (int i = 0; i < 4; i++) clock_bit(1'($urandom_range(0, 1)), r);
    i2c_stop();
    repeat (4) @(negedge clk);
    chk("partial_busy", busy, 0);
    drained("partial");
    chk("partial_rx_unchanged", rx_data, 8'h99);

    // Randomized transactions.
    for (int t = 0; t < 20; t++) begin
      addr = ($urandom_range(0, 3) == 0) ? 7'($urandom) : TADDR;
      rd   = 1'($urandom_range(0, 1));
      n    = $urandom_range(1, 3);
      stp  = (t == 19) ? 1'b1 : ($urandom_range(0, 3) != 0);
      do_txn(addr, rd, n, $urandom, stp);
    end
    drained("random");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
